// File: rtl/pwm_pkg.sv
// Shared PWM definitions: counter widths, dead-time FSM states and the
// state-to-gate-drive decode used by the dead-time stage.
package pwm_pkg;

  localparam int DT_W_DEF  = 16;
  localparam int PWM_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_LOW     = 3'd1,
    ST_DT_RISE = 3'd2,
    ST_HIGH    = 3'd3,
    ST_DT_FALL = 3'd4,
    ST_BREAK   = 3'd5
  } dt_state_e;

  // {out_h, out_l}; only the two settled states ever drive a gate
  function automatic logic [1:0] drive_of(input dt_state_e s);
    logic [1:0] drv;
    case (s)
      ST_HIGH: drv = 2'b10;
      ST_LOW:  drv = 2'b01;
      default: drv = 2'b00;
    endcase
    return drv;
  endfunction

endpackage

// File: rtl/pwm_dt_counter.sv
// Loadable down-counter that times the dead-time interval; zero flags the
// last cycle of the gap.
module pwm_dt_counter
  import pwm_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [DT_W-1:0] load_val,
  input  logic            dec,
  output logic            zero
);

  logic [DT_W-1:0] cnt;

  // load takes precedence over decrement
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= {DT_W{1'b0}};
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - {{(DT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

  assign zero = (cnt == {DT_W{1'b0}});

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary gate-drive generator with programmable dead-time and a
// latched break input that holds both gates off until cleared.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            wave,
  input  logic [DT_W-1:0] dtr,
  input  logic            brk,
  input  logic            brk_clr,
  output logic            out_h,
  output logic            out_l,
  output logic            brk_flag,
  output logic [2:0]      state
);

  dt_state_e       cur;
  dt_state_e       nxt;
  logic            load;
  logic            dec;
  logic            zero;
  logic [DT_W-1:0] load_val;

  pwm_dt_counter #(.DT_W(DT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .zero     (zero)
  );

  // Next-state and counter control; brk outranks en, en outranks wave
  always_comb begin
    nxt  = cur;
    load = 1'b0;
    dec  = 1'b0;
    // dtr=0 only reaches a load from OFF, where it still buys one dead cycle
    if (dtr == {DT_W{1'b0}}) begin
      load_val = {DT_W{1'b0}};
    end else begin
      load_val = dtr - {{(DT_W-1){1'b0}}, 1'b1};
    end

    if (brk) begin
      nxt = ST_BREAK;
    end else if (cur == ST_BREAK) begin
      if (brk_clr) begin
        nxt = ST_OFF;
      end else begin
        nxt = ST_BREAK;
      end
    end else if (!en) begin
      nxt = ST_OFF;
    end else begin
      case (cur)
        ST_OFF: begin
          if (wave) begin
            nxt  = ST_DT_RISE;
            load = 1'b1;
          end else begin
            nxt = ST_LOW;
          end
        end
        ST_LOW: begin
          if (!wave) begin
            nxt = ST_LOW;
          end else if (dtr == {DT_W{1'b0}}) begin
            nxt = ST_HIGH;
          end else begin
            nxt  = ST_DT_RISE;
            load = 1'b1;
          end
        end
        ST_DT_RISE: begin
          if (!wave) begin
            nxt = ST_LOW;
          end else if (zero) begin
            nxt = ST_HIGH;
          end else begin
            nxt = ST_DT_RISE;
            dec = 1'b1;
          end
        end
        ST_HIGH: begin
          if (wave) begin
            nxt = ST_HIGH;
          end else if (dtr == {DT_W{1'b0}}) begin
            nxt = ST_LOW;
          end else begin
            nxt  = ST_DT_FALL;
            load = 1'b1;
          end
        end
        ST_DT_FALL: begin
          if (wave) begin
            nxt = ST_HIGH;
          end else if (zero) begin
            nxt = ST_LOW;
          end else begin
            nxt = ST_DT_FALL;
            dec = 1'b1;
          end
        end
        default: nxt = ST_OFF;
      endcase
    end
  end

  // State register with outputs decoded from the state being entered
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur      <= ST_OFF;
      out_h    <= 1'b0;
      out_l    <= 1'b0;
      brk_flag <= 1'b0;
    end else begin
      cur            <= nxt;
      {out_h, out_l} <= drive_of(nxt);
      brk_flag       <= (nxt == ST_BREAK);
    end
  end

  assign state = cur;

endmodule
